// File: rtl/mult_arb_pkg.sv
// Shared definitions for the shared-multiplier arbiter slice.
package mult_arb_pkg;

  localparam int OP_W   = 32;
  localparam int PROD_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } mult_arb_state_t;

endpackage

// File: rtl/multiplier.sv
// Purely combinational unsigned 32x32 -> 64 multiplier datapath.
module multiplier
  import mult_arb_pkg::*;
(
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  output logic [PROD_W-1:0] p_o
);

  assign p_o = PROD_W'(a_i) * PROD_W'(b_i);

endmodule

// File: rtl/rr_arbiter.sv
// Request arbiter: round-robin from ptr by default; with
// MULT_ARB_FIXED_PRIO_EN defined, the lowest valid index wins and ptr is ignored.
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx
);

  logic found;

`ifdef MULT_ARB_FIXED_PRIO_EN
  logic ptr_unused;
  assign ptr_unused = ^ptr;

  // Lowest set request bit wins.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(i);
      end
    end
  end
`else
  int unsigned idx;

  // First set request bit at or after ptr, wrapping N-1 -> 0.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
  end
`endif

  assign gnt = found ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx) : '0;

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one combinational multiplier among NUM_REQ valid/ready requesters.
// Operands are held LAT cycles before the product is registered and returned
// with the requester index. Optional macro: MULT_ARB_FIXED_PRIO_EN.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int LAT     = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [PROD_W-1:0]       rsp_p,
  output logic                    busy
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  mult_arb_state_t     state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [OP_W-1:0]     a_q;
  logic [OP_W-1:0]     b_q;
  logic [ID_W-1:0]     id_q;
  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [PROD_W-1:0]   rsp_p_q;

  logic [ID_W-1:0]     ptr;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_idx;
  logic [PROD_W-1:0]   prod;
  logic                accept;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  multiplier u_mult (
    .a_i (a_q),
    .b_i (b_q),
    .p_o (prod)
  );

  assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;
  assign accept    = (state_q == IDLE) && (|gnt);

`ifdef MULT_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;

  assign ptr   = ptr_q;
  assign ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Round-robin pointer moves past the winner on every accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Issue / settle / respond sequencer with registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_p_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= req_a[OP_W*int'(gnt_idx) +: OP_W];
            b_q     <= req_b[OP_W*int'(gnt_idx) +: OP_W];
            id_q    <= gnt_idx;
            cnt_q   <= CNT_W'(LAT - 1);
            state_q <= CALC;
          end
        end
        CALC: begin
          if (cnt_q == '0) begin
            rsp_p_q     <= prod;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter (honours MULT_ARB_FIXED_PRIO_EN).
module tb_mult_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int LAT     = 2;
  localparam int ID_W    = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*32-1:0]   req_a;
  logic [NUM_REQ*32-1:0]   req_b;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [63:0]             rsp_p;
  logic                    busy;

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;
  int cyc = 0;

  mult_share_arbiter #(.NUM_REQ(NUM_REQ), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: winner among valid requesters.
  function automatic int model_grant(input logic [NUM_REQ-1:0] m);
`ifdef MULT_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) if (m[i]) return i;
`else
    for (int i = model_ptr; i < NUM_REQ; i++) if (m[i]) return i;
    for (int i = 0; i < model_ptr; i++) if (m[i]) return i;
`endif
    return -1;
  endfunction

  function automatic logic [63:0] onehot(input int g);
    return (g < 0) ? 64'd0 : (64'd1 << g);
  endfunction

  task automatic note_grant(input int g);
`ifndef MULT_ARB_FIXED_PRIO_EN
    model_ptr = (g + 1) % NUM_REQ;
`endif
  endtask

  // One full transaction: grant, latency, product, held response, release.
  task automatic issue(input logic [NUM_REQ-1:0] mask, input logic [NUM_REQ*32-1:0] av,
                       input logic [NUM_REQ*32-1:0] bv, input int hold);
    int g;
    int n;
    logic [63:0] exp_p;
    logic [31:0] ea, eb;
    g = model_grant(mask);
    req_valid = mask; req_a = av; req_b = bv; rsp_ready = 1'b0;
    @(negedge clk);
    chk("grant", 64'(req_ready), onehot(g));
    if (g < 0) begin
      req_valid = '0;
      return;
    end
    ea = av[32*g +: 32];
    eb = bv[32*g +: 32];
    exp_p = {32'd0, ea} * {32'd0, eb};
    @(posedge clk); #1;
    req_valid = '0;
    note_grant(g);
    chk("busy_calc", 64'(busy), 64'd1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), 64'(LAT));
    chk("rsp_p", rsp_p, exp_p);
    chk("rsp_id", 64'(rsp_id), 64'(g));
    chk("ready_resp", 64'(req_ready), 64'd0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_p", rsp_p, exp_p);
      chk("hold_id", 64'(rsp_id), 64'(g));
      chk("hold_busy", 64'(busy), 64'd1);
      chk("hold_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("release_valid", 64'(rsp_valid), 64'd0);
    chk("release_busy", 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_ptr = 0;
  endtask

  logic [NUM_REQ*32-1:0] av, bv;
  logic [NUM_REQ-1:0]    fmask;
  int                    g, last_cyc, n;

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    do_reset();
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_p", rsp_p, 64'd0);
    chk("rst_id", 64'(rsp_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // rsp_ready without a response has no effect
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_rspready_valid", 64'(rsp_valid), 64'd0);
    chk("idle_rspready_busy", 64'(busy), 64'd0);
    rsp_ready = 1'b0;

    // Basic op on requester 2
    av = '0; bv = '0;
    av[64 +: 32] = 32'd3; bv[64 +: 32] = 32'd5;
    issue(4'b0100, av, bv, 0);

    // Max operands
    av[0 +: 32] = 32'hFFFF_FFFF; bv[0 +: 32] = 32'hFFFF_FFFF;
    issue(4'b0001, av, bv, 1);
    av[96 +: 32] = 32'h8000_0000; bv[96 +: 32] = 32'd2;
    issue(4'b1000, av, bv, 0);

    // Backpressure: response held 5 cycles
    for (int i = 0; i < NUM_REQ; i++) begin
      av[32*i +: 32] = $urandom; bv[32*i +: 32] = $urandom;
    end
    issue(4'b0010, av, bv, 5);

    // Randomized operations
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        av[32*i +: 32] = $urandom; bv[32*i +: 32] = $urandom;
      end
      fmask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      issue(fmask, av, bv, int'($urandom_range(0, 3)));
    end

    // No requester valid: nothing granted
    issue(4'b0000, av, bv, 0);
    chk("no_req_busy", 64'(busy), 64'd0);

    // Reset during CALC discards the op
    req_valid = 4'b0001;
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 4'b1010;
    @(negedge clk);
    chk("rst_ready_forced", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    chk("midrst_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_p", rsp_p, 64'd0);
    chk("midrst_id", 64'(rsp_id), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    model_ptr = 0;
    issue(4'b1010, av, bv, 0);

    // Fairness / fixed priority under continuous requests, rsp_ready high
    do_reset();
`ifdef MULT_ARB_FIXED_PRIO_EN
    fmask = 4'b1001;
`else
    fmask = 4'b1111;
`endif
    req_valid = fmask; rsp_ready = 1'b1;
    last_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      g = model_grant(fmask);
      n = 0;
      @(negedge clk);
      while (req_ready == '0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("fair_grant", 64'(req_ready), onehot(g));
      if (k > 0) chk("fair_period", 64'(cyc - last_cyc), 64'(LAT + 2));
      last_cyc = cyc;
      note_grant(g);
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("fair_rsp_id", 64'(rsp_id), 64'(g));
      chk("fair_rsp_p", rsp_p, {32'd0, av[32*g +: 32]} * {32'd0, bv[32*g +: 32]});
    end
    req_valid = '0; rsp_ready = 1'b0;
    repeat (4) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
